// File: rtl/dino_jump_ctrl_if.sv
// Dinosaur jump controller bundle: button/game inputs and renderer outputs.
// master drives jump_btn/duck_btn/halt/gs; slave drives y_off/frame_addr/airborne/tick.
interface dino_jump_ctrl_if #(
    parameter int ADDR_W = 10
);
    logic              jump_btn;
    logic              duck_btn;
    logic              halt;
    logic              gs;
    logic [7:0]        y_off;
    logic [ADDR_W-1:0] frame_addr;
    logic              airborne;
    logic              tick;

    modport master (
        output jump_btn, duck_btn, halt, gs,
        input  y_off, frame_addr, airborne, tick
    );

    modport slave (
        input  jump_btn, duck_btn, halt, gs,
        output y_off, frame_addr, airborne, tick
    );
endinterface

// File: rtl/dino_jump_ctrl.sv
// Dinosaur jump controller: turns a jump press into a rise/hang/fall arc
// and selects the run, duck, air or dead sprite frame.
// Ports: clk, reset (sync, active-high), bus (slave side of dino_jump_ctrl_if):
//   in  jump_btn, duck_btn, halt, gs; out y_off, frame_addr, airborne, tick.
module dino_jump_ctrl #(
    parameter int TICK_DIV   = 251250,
    parameter int JUMP_H     = 64,
    parameter int STEP       = 4,
    parameter int HANG_TICKS = 6,
    parameter int ADDR_W     = 10
) (
    input  logic             clk,
    input  logic             reset,
    dino_jump_ctrl_if.slave  bus
);
    localparam int CNT_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int HANG_W = $clog2(HANG_TICKS + 1);

    localparam logic [2:0] S_GROUND = 3'd0;
    localparam logic [2:0] S_RISE   = 3'd1;
    localparam logic [2:0] S_HANG   = 3'd2;
    localparam logic [2:0] S_FALL   = 3'd3;
    localparam logic [2:0] S_DEAD   = 3'd4;

    localparam logic [ADDR_W-1:0] F_RUN0  = ADDR_W'(0);
    localparam logic [ADDR_W-1:0] F_RUN1  = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] F_AIR   = ADDR_W'(2);
    localparam logic [ADDR_W-1:0] F_DEAD  = ADDR_W'(3);
    localparam logic [ADDR_W-1:0] F_DUCK0 = ADDR_W'(4);
    localparam logic [ADDR_W-1:0] F_DUCK1 = ADDR_W'(5);

    logic [2:0]        state;
    logic [7:0]        y_q;
    logic [ADDR_W-1:0] frame_q;
    logic [CNT_W-1:0]  cnt;
    logic [HANG_W-1:0] hang;
    logic              pending;
    logic              btn_q;

    logic              tick_w;
    logic              press;
    logic              go;
    logic [8:0]        y_up;
    logic [ADDR_W-1:0] run_next;

    // Prescaler is frozen in DEAD and may sit at its terminal count,
    // so the pulse is gated by state.
    assign tick_w = (state != S_DEAD) && (cnt == CNT_W'(TICK_DIV - 1));
    assign press  = bus.jump_btn & ~btn_q;
    assign go     = pending | press;
    // One extra bit so JUMP_H near 255 cannot wrap before saturating.
    assign y_up   = {1'b0, y_q} + 9'(STEP);

    always_comb begin
        run_next = F_RUN0;
        if (bus.duck_btn) begin
            run_next = (frame_q == F_DUCK0) ? F_DUCK1 : F_DUCK0;
        end else begin
            run_next = (frame_q == F_RUN0) ? F_RUN1 : F_RUN0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || !bus.gs) begin
            state   <= S_GROUND;
            y_q     <= '0;
            frame_q <= F_RUN0;
            cnt     <= '0;
            hang    <= '0;
            pending <= 1'b0;
            btn_q   <= 1'b0;
        end else begin
            btn_q <= bus.jump_btn;
            if (state != S_DEAD) begin
                if (bus.halt) begin
                    state   <= S_DEAD;
                    frame_q <= F_DEAD;
                end else begin
                    cnt <= tick_w ? '0 : cnt + CNT_W'(1);
                    unique case (state)
                        S_GROUND: begin
                            if (tick_w) begin
                                if (go) begin
                                    pending <= 1'b0;
                                    state   <= S_RISE;
                                    frame_q <= F_AIR;
                                end else begin
                                    frame_q <= run_next;
                                end
                            end else if (press) begin
                                pending <= 1'b1;
                            end
                        end
                        S_RISE: begin
                            if (tick_w) begin
                                if (y_up >= 9'(JUMP_H)) begin
                                    y_q   <= 8'(JUMP_H);
                                    hang  <= '0;
                                    state <= S_HANG;
                                end else begin
                                    y_q <= y_up[7:0];
                                end
                            end
                        end
                        S_HANG: begin
                            if (tick_w) begin
                                if (hang == HANG_W'(HANG_TICKS - 1)) begin
                                    state <= S_FALL;
                                end else begin
                                    hang <= hang + HANG_W'(1);
                                end
                            end
                        end
                        S_FALL: begin
                            if (tick_w) begin
                                if (y_q <= 8'(STEP)) begin
                                    y_q     <= '0;
                                    state   <= S_GROUND;
                                    frame_q <= F_RUN0;
                                end else begin
                                    y_q <= y_q - 8'(STEP);
                                end
                            end
                        end
                        default: begin
                        end
                    endcase
                end
            end
        end
    end

    assign bus.y_off      = y_q;
    assign bus.frame_addr = frame_q;
    assign bus.tick       = tick_w;
    assign bus.airborne   = (state == S_RISE) ||
                            (state == S_HANG) ||
                            (state == S_FALL);
endmodule

// File: tb/tb_dino_jump_ctrl.sv
// Testbench for dino_jump_ctrl: directed scenarios plus random stimulus,
// every cycle compared against a tick-level arc model.
module tb_dino_jump_ctrl;
    localparam int TD = 4;
    localparam int JH = 10;
    localparam int ST = 4;
    localparam int HT = 2;
    localparam int AW = 10;

    logic clk;
    logic reset;
    int   n_chk;
    int   n_err;

    dino_jump_ctrl_if #(.ADDR_W(AW)) bus ();

    dino_jump_ctrl #(
        .TICK_DIV  (TD),
        .JUMP_H    (JH),
        .STEP      (ST),
        .HANG_TICKS(HT),
        .ADDR_W    (AW)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: a jump is a precomputed queue of post-tick heights.
    int m_cnt;
    int m_y;
    int m_frame;
    bit m_pend;
    bit m_prev;
    bit m_dead;
    int m_arc[$];

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0d expected %0d",
                     tag, $time, got, exp);
        end
    endtask

    function automatic void build_arc();
        int h;
        m_arc.delete();
        h = 0;
        while (h < JH) begin
            h = (h + ST > JH) ? JH : h + ST;
            m_arc.push_back(h);
        end
        for (int i = 0; i < HT; i++) m_arc.push_back(JH);
        while (h > ST) begin
            h = h - ST;
            m_arc.push_back(h);
        end
        m_arc.push_back(0);
    endfunction

    function automatic void model_clear();
        m_cnt   = 0;
        m_y     = 0;
        m_frame = 0;
        m_pend  = 0;
        m_prev  = 0;
        m_dead  = 0;
        m_arc.delete();
    endfunction

    function automatic void model_edge();
        bit press;
        bit tk;
        if (reset || !bus.gs) begin
            model_clear();
            return;
        end
        press  = bus.jump_btn && !m_prev;
        m_prev = bus.jump_btn;
        if (m_dead) return;
        if (bus.halt) begin
            m_dead  = 1;
            m_frame = 3;
            return;
        end
        tk    = (m_cnt == TD - 1);
        m_cnt = tk ? 0 : m_cnt + 1;
        if (m_arc.size() == 0) begin
            if (tk) begin
                if (m_pend || press) begin
                    m_pend  = 0;
                    build_arc();
                    m_frame = 2;
                end else if (bus.duck_btn) begin
                    m_frame = (m_frame == 4) ? 5 : 4;
                end else begin
                    m_frame = (m_frame == 0) ? 1 : 0;
                end
            end else if (press) begin
                m_pend = 1;
            end
        end else if (tk) begin
            m_y = m_arc.pop_front();
            if (m_arc.size() == 0) m_frame = 0;
        end
    endfunction

    task automatic step(input logic r, input logic g, input logic j,
                        input logic d, input logic h);
        reset        = r;
        bus.gs       = g;
        bus.jump_btn = j;
        bus.duck_btn = d;
        bus.halt     = h;
        @(posedge clk);
        model_edge();
        #1;
        check("y_off", 32'(bus.y_off), 32'(m_y));
        check("frame_addr", 32'(bus.frame_addr), 32'(m_frame));
        check("airborne", 32'(bus.airborne),
              32'(!m_dead && m_arc.size() > 0));
        check("tick", 32'(bus.tick), 32'(!m_dead && m_cnt == TD - 1));
    endtask

    task automatic run_until_y(input int y, input string tag);
        int k;
        k = 0;
        while (m_y != y && k < 200) begin
            step(0, 1, 0, 0, 0);
            k++;
        end
        if (m_y != y) check(tag, 0, 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit j;
        bit d;
        bit h;
        bit g;
        bit r;
        n_chk = 0;
        n_err = 0;
        model_clear();
        reset        = 1'b1;
        bus.gs       = 1'b1;
        bus.jump_btn = 1'b0;
        bus.duck_btn = 1'b0;
        bus.halt     = 1'b0;

        // Reset, then idle running.
        step(1, 1, 0, 0, 0);
        step(1, 1, 0, 0, 0);
        for (int i = 0; i < 12; i++) step(0, 1, 0, 0, 0);

        // Single jump, saturating at JH.
        step(0, 1, 1, 0, 0);
        for (int i = 0; i < 50; i++) step(0, 1, 0, 0, 0);
        check("landed_ground", 32'(bus.airborne), 0);

        // Collision mid-rise, halt release, then gs drop.
        step(0, 1, 1, 0, 0);
        run_until_y(8, "wait_rise_y8");
        for (int i = 0; i < 10; i++) step(0, 1, 0, 0, 1);
        check("dead_y", 32'(bus.y_off), 8);
        check("dead_frame", 32'(bus.frame_addr), 3);
        for (int i = 0; i < 10; i++) step(0, 1, 0, 0, 0);
        check("still_dead", 32'(bus.frame_addr), 3);
        step(0, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0);

        // Press during hang, button held across landing.
        step(0, 1, 1, 0, 0);
        run_until_y(JH, "wait_hang");
        step(0, 1, 0, 0, 0);
        for (int i = 0; i < 60; i++) step(0, 1, 1, 0, 0);
        check("no_rejump", 32'(bus.airborne), 0);
        step(0, 1, 0, 0, 0);
        step(0, 1, 1, 0, 0);
        for (int i = 0; i < 8; i++) step(0, 1, 0, 0, 0);
        check("rejump", 32'(bus.airborne), 1);
        for (int i = 0; i < 50; i++) step(0, 1, 0, 0, 0);

        // Duck frames, then reset mid-fall.
        for (int i = 0; i < 20; i++) step(0, 1, 0, 1, 0);
        step(0, 1, 1, 0, 0);
        run_until_y(JH, "wait_peak");
        run_until_y(6, "wait_fall_y6");
        step(1, 1, 0, 0, 0);
        check("reset_y", 32'(bus.y_off), 0);
        check("reset_frame", 32'(bus.frame_addr), 0);

        // Random stimulus.
        j = 0;
        d = 0;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 7) == 0) j = ~j;
            if ($urandom_range(0, 29) == 0) d = ~d;
            h = ($urandom_range(0, 299) == 0);
            g = ($urandom_range(0, 99) != 0);
            r = ($urandom_range(0, 699) == 0);
            step(r, g, j, d, h);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_err);
        $finish;
    end
endmodule
